// File: rtl/pipelined_shift_unit.sv
// Pipelined barrel shifter (sll/srl/sra/rol/ror) with valid/ready stall.
// Define SHIFT_FLAGS_EN to add registered out_zero/out_carry outputs.
module pipelined_shift_unit #(
  parameter int N = 32,
  parameter int STAGES = 2,
  localparam int K = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [K-1:0] in_b,
  input  logic [2:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_r
`ifdef SHIFT_FLAGS_EN
  ,
  output logic         out_zero,
  output logic         out_carry
`endif
);

  localparam int LPS = (K + STAGES - 1) / STAGES;
  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  logic w_en;
  assign w_en = out_ready | ~out_valid;
  assign in_ready = w_en;

  function automatic logic [N-1:0] f_lvl(
    input logic [N-1:0] d,
    input logic [2:0]   op,
    input logic         sg,
    input int           m
  );
    logic [N-1:0] v_fill;
    logic [N-1:0] v_r;
    v_fill = sg ? ~({N{1'b1}} >> m) : '0;
    case (op)
      OP_SLL:  v_r = d << m;
      OP_SRL:  v_r = d >> m;
      OP_SRA:  v_r = (d >> m) | v_fill;
      OP_ROL:  v_r = (d << m) | (d >> (N - m));
      OP_ROR:  v_r = (d >> m) | (d << (N - m));
      default: v_r = d;
    endcase
    return v_r;
  endfunction

`ifdef SHIFT_FLAGS_EN
  // The last level that actually shifts decides the carry.
  function automatic logic f_cy(
    input logic [N-1:0] d,
    input logic [N-1:0] nx,
    input logic [2:0]   op,
    input int           m
  );
    logic [N-1:0] v_t;
    logic         v_c;
    v_t = '0;
    v_c = 1'b0;
    case (op)
      OP_SLL: begin
        v_t = d >> (N - m);
        v_c = v_t[0];
      end
      OP_SRL, OP_SRA: begin
        v_t = d >> (m - 1);
        v_c = v_t[0];
      end
      OP_ROL:  v_c = nx[0];
      OP_ROR:  v_c = nx[N-1];
      default: v_c = 1'b0;
    endcase
    return v_c;
  endfunction
`endif

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO = s * LPS;
    localparam int HI = (LO + LPS > K) ? K : LO + LPS;

    logic         w_vi;
    logic         w_sgi;
    logic [N-1:0] w_di;
    logic [N-1:0] w_do;
    logic [N-1:0] w_nx;
    logic [K-1:0] w_bi;
    logic [2:0]   w_opi;
    logic         r_v;
    logic [N-1:0] r_d;
`ifdef SHIFT_FLAGS_EN
    logic w_ci;
    logic w_co;
    logic r_c;
`endif

    if (s == 0) begin : g_src
      assign w_vi  = in_valid;
      assign w_di  = in_a;
      assign w_bi  = in_b;
      assign w_opi = in_op;
      assign w_sgi = in_a[N-1];
`ifdef SHIFT_FLAGS_EN
      assign w_ci  = 1'b0;
`endif
    end else begin : g_src
      assign w_vi  = g_st[s-1].r_v;
      assign w_di  = g_st[s-1].r_d;
      assign w_bi  = g_st[s-1].g_mid.r_b;
      assign w_opi = g_st[s-1].g_mid.r_op;
      assign w_sgi = g_st[s-1].g_mid.r_sg;
`ifdef SHIFT_FLAGS_EN
      assign w_ci  = g_st[s-1].r_c;
`endif
    end

    always_comb begin
      w_do = w_di;
      w_nx = w_di;
`ifdef SHIFT_FLAGS_EN
      w_co = w_ci;
`endif
      for (int i = 0; i < K; i++) begin
        if (i >= LO && i < HI && w_bi[i]) begin
          w_nx = f_lvl(w_do, w_opi, w_sgi, 1 << i);
`ifdef SHIFT_FLAGS_EN
          w_co = f_cy(w_do, w_nx, w_opi, 1 << i);
`endif
          w_do = w_nx;
        end
      end
    end

    // Data only loads with a valid op so an empty pipe keeps out_r.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_v <= 1'b0;
        r_d <= '0;
`ifdef SHIFT_FLAGS_EN
        r_c <= 1'b0;
`endif
      end else if (w_en) begin
        r_v <= w_vi;
        if (w_vi) begin
          r_d <= w_do;
`ifdef SHIFT_FLAGS_EN
          r_c <= w_co;
`endif
        end
      end
    end

    if (s < STAGES - 1) begin : g_mid
      logic [K-1:0] r_b;
      logic [2:0]   r_op;
      logic         r_sg;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_b  <= '0;
          r_op <= '0;
          r_sg <= 1'b0;
        end else if (w_en && w_vi) begin
          r_b  <= w_bi;
          r_op <= w_opi;
          r_sg <= w_sgi;
        end
      end
    end

`ifdef SHIFT_FLAGS_EN
    if (s == STAGES - 1) begin : g_z
      logic r_z;
      always_ff @(posedge clk) begin
        if (reset) r_z <= 1'b0;
        else if (w_en && w_vi) r_z <= (w_do == '0);
      end
    end
`endif
  end

  assign out_valid = g_st[STAGES-1].r_v;
  assign out_r     = g_st[STAGES-1].r_d;
`ifdef SHIFT_FLAGS_EN
  assign out_carry = g_st[STAGES-1].r_c;
  assign out_zero  = g_st[STAGES-1].g_z.r_z;
`endif

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Scoreboard bench for pipelined_shift_unit (STAGES=2 main, 1 and 5 sweep).
// Flag outputs are checked when SHIFT_FLAGS_EN is defined.
module tb_pipelined_shift_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, out_ready;
  logic [31:0] in_a;
  logic [4:0]  in_b;
  logic [2:0]  in_op;
  logic        rdy2, rdy1, rdy5, ov2, ov1, ov5;
  logic [31:0] r2, r1, r5;
  logic        c2, z2, c1, z1, c5, z5;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        z;
    int          cyc;
    bit          lat;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [4:0]  b;
    logic [31:0] r;
    logic        c;
    logic        z;
  } vec_t;

  localparam vec_t TV [14] = '{
    '{3'd0, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0},
    '{3'd1, 32'h80000000, 5'd4,  32'h08000000, 1'b0, 1'b0},
    '{3'd2, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0},
    '{3'd3, 32'h80000001, 5'd1,  32'h00000003, 1'b1, 1'b0},
    '{3'd4, 32'h80000001, 5'd1,  32'hC0000000, 1'b1, 1'b0},
    '{3'd7, 32'h12345678, 5'd5,  32'h12345678, 1'b0, 1'b0},
    '{3'd2, 32'h7FFFFFFF, 5'd31, 32'h00000000, 1'b1, 1'b1},
    '{3'd2, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0},
    '{3'd3, 32'h12345678, 5'd8,  32'h34567812, 1'b0, 1'b0},
    '{3'd4, 32'h12345678, 5'd4,  32'h81234567, 1'b1, 1'b0},
    '{3'd1, 32'hFFFFFFFF, 5'd31, 32'h00000001, 1'b1, 1'b0},
    '{3'd1, 32'h00000003, 5'd1,  32'h00000001, 1'b1, 1'b0},
    '{3'd0, 32'h80000000, 5'd1,  32'h00000000, 1'b1, 1'b1},
    '{3'd4, 32'h00000001, 5'd1,  32'h80000000, 1'b1, 1'b0}
  };

  exp_t q2[$], q1[$], q5[$];
  exp_t cur;
  int   tests = 0, fails = 0, cyc = 0;
  bit   lat_en, rnd;

  pipelined_shift_unit #(.N(32), .STAGES(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(ov2),
    .out_ready(out_ready), .out_r(r2)
`ifdef SHIFT_FLAGS_EN
    , .out_zero(z2), .out_carry(c2)
`endif
  );

  pipelined_shift_unit #(.N(32), .STAGES(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(ov1),
    .out_ready(1'b1), .out_r(r1)
`ifdef SHIFT_FLAGS_EN
    , .out_zero(z1), .out_carry(c1)
`endif
  );

  pipelined_shift_unit #(.N(32), .STAGES(5)) u5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy5),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(ov5),
    .out_ready(1'b1), .out_r(r5)
`ifdef SHIFT_FLAGS_EN
    , .out_zero(z5), .out_carry(c5)
`endif
  );

`ifndef SHIFT_FLAGS_EN
  assign {c2, z2, c1, z1, c5, z5} = '0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] m_r(
    input logic [2:0] op, input logic [31:0] a, input logic [4:0] b
  );
    int s;
    s = int'(b);
    case (op)
      3'd0: return a << s;
      3'd1: return a >> s;
      3'd2: return 32'($signed(a) >>> s);
      3'd3: return (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      3'd4: return (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      default: return a;
    endcase
  endfunction

  function automatic logic m_c(
    input logic [2:0] op, input logic [31:0] a, input logic [4:0] b
  );
    logic [31:0] t, r;
    int s;
    s = int'(b);
    r = m_r(op, a, b);
    if (s == 0 || op > 3'd4) return 1'b0;
    case (op)
      3'd0: begin t = a >> (32 - s); return t[0]; end
      3'd3: return r[0];
      3'd4: return r[31];
      default: begin t = a >> (s - 1); return t[0]; end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [31:0] r,
                     input logic c, input logic z, input int stg);
    chk({tag, " result"}, r, e.r);
`ifdef SHIFT_FLAGS_EN
    chk({tag, " carry"}, 32'(c), 32'(e.c));
    chk({tag, " zero"}, 32'(z), 32'(e.z));
`endif
    if (e.lat) chk({tag, " latency"}, cyc - e.cyc, stg);
  endtask

  task automatic unexp(input string tag, input logic [31:0] r);
    tests++;
    fails++;
    $display("FAIL %s unexpected output: got %h want none", tag, r);
  endtask

  // Monitor: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    exp_t m, e;
    if (reset) begin
      q2.delete(); q1.delete(); q5.delete();
    end else begin
      m.r = m_r(in_op, in_a, in_b);
      m.c = m_c(in_op, in_a, in_b);
      m.z = (m.r == 32'd0);
      m.cyc = cyc;
      m.lat = 1'b1;
      e = cur;
      e.cyc = cyc;
      e.lat = lat_en;
      if (in_valid && rdy2) q2.push_back(e);
      if (in_valid && rdy1) q1.push_back(m);
      if (in_valid && rdy5) q5.push_back(m);
      if (ov2 && out_ready) begin
        if (q2.size() == 0) unexp("s2", r2);
        else cmp("s2", q2.pop_front(), r2, c2, z2, 2);
      end
      if (ov1) begin
        if (q1.size() == 0) unexp("s1", r1);
        else cmp("s1", q1.pop_front(), r1, c1, z1, 1);
      end
      if (ov5) begin
        if (q5.size() == 0) unexp("s5", r5);
        else cmp("s5", q5.pop_front(), r5, c5, z5, 5);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a,
                      input logic [4:0] b, input logic [31:0] er,
                      input logic ec, input logic ez);
    int  n;
    bit  ok;
    n = 0;
    in_valid = 1'b1;
    in_op = op; in_a = a; in_b = b;
    cur.r = er; cur.c = ec; cur.z = ez;
    do begin
      @(negedge clk);
      ok = rdy2;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send timeout: got in_ready 0 want 1");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [4:0]  b;
    logic [31:0] er;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = '0;
    lat_en = 1'b1; rnd = 1'b0;
    cur = '{r: 32'd0, c: 1'b0, z: 1'b0, cyc: 0, lat: 1'b0};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset out_valid", 32'(ov2), 32'd0);
    chk("reset out_r", r2, 32'd0);
    chk("reset in_ready", 32'(rdy2), 32'd1);

    foreach (TV[i]) send(TV[i].op, TV[i].a, TV[i].b, TV[i].r, TV[i].c, TV[i].z);
    for (int k = 0; k < 8; k++)
      send(3'(k), 32'hDEADBEEF, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0);
    idle(8);

    // Backpressure: four sll ops, output held off for three cycles.
    lat_en = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++)
          send(3'd0, 32'd1, 5'(k), 32'd1 << k, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!ov2 && n < 20);
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          chk("stall out_valid", 32'(ov2), 32'd1);
          chk("stall out_r", r2, 32'd1);
          chk("stall in_ready", 32'(rdy2), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(8);
    chk("backpressure drained", 32'(q2.size()), 32'd0);

    // Reset with two ops in flight; an op during reset is not accepted.
    lat_en = 1'b1;
    send(3'd0, 32'd1, 5'd2, 32'd4, 1'b0, 1'b0);
    send(3'd1, 32'h100, 5'd4, 32'h10, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    chk("flush out_valid", 32'(ov2), 32'd0);
    chk("flush out_r", r2, 32'd0);
    chk("flush in_ready", 32'(rdy2), 32'd1);
    idle(5);
    send(3'd4, 32'h10, 5'd4, 32'h1, 1'b0, 1'b0);
    idle(6);
    chk("post-reset drained", 32'(q2.size()), 32'd0);

    // Random ops against the model with random output backpressure.
    lat_en = 1'b0;
    rnd = 1'b1;
    fork
      while (rnd) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int k = 0; k < 1000; k++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = 5'($urandom_range(0, 31));
      er = m_r(op, a, b);
      send(op, a, b, er, m_c(op, a, b), er == 32'd0);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    rnd = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    idle(20);
    chk("s2 drained", 32'(q2.size()), 32'd0);
    chk("s1 drained", 32'(q1.size()), 32'd0);
    chk("s5 drained", 32'(q5.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
